// File: rtl/exu_fpu_seq.sv
// Single-outstanding FP32 issue sequencer between EXU issue and an FPnew datapath.
// Latches one request, runs both FPU handshakes, writes back and accumulates sticky flags.
module exu_fpu_seq #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [31:0] req_c,
   input  logic [4:0]  req_rd,
   input  logic [2:0]  req_rm,
   input  logic        flush,
   output logic        stall,
   output logic [95:0] fpu_operands,
   output logic [3:0]  fpu_op,
   output logic        fpu_op_mod,
   output logic [2:0]  fpu_rnd,
   output logic        fpu_in_valid,
   input  logic        fpu_in_ready,
   output logic        fpu_flush,
   input  logic [31:0] fpu_result,
   input  logic [4:0]  fpu_status,
   input  logic        fpu_out_valid,
   output logic        fpu_out_ready,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [4:0]  fflags,
   input  logic        fflags_clr,
   output logic        illegal_op,
   output logic        timeout_err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   // Abort decision is taken one cycle early so the registered error/flush
   // outputs appear exactly when the counter would read TIMEOUT-1.
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

   // fpnew_pkg::operation_e encodings
   localparam logic [3:0] FP_FMADD  = 4'd0;
   localparam logic [3:0] FP_FNMSUB = 4'd1;
   localparam logic [3:0] FP_ADD    = 4'd2;
   localparam logic [3:0] FP_MUL    = 4'd3;
   localparam logic [3:0] FP_DIV    = 4'd4;
   localparam logic [3:0] FP_SQRT   = 4'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [95:0]   ops_q, ops_d;
   logic [3:0]    op_q, op_d;
   logic          mod_q, mod_d;
   logic [2:0]    rm_q, rm_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   res_q, res_d;
   logic [4:0]    status_q, status_d;
   logic [4:0]    fflags_q, fflags_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fpu_flush_q, fpu_flush_d;
   logic          illegal_q, illegal_d;
   logic          timeout_q, timeout_d;

   logic          accept_s;
   logic [95:0]   map_ops_s;
   logic [3:0]    map_op_s;
   logic          map_mod_s;

   assign accept_s = (state_q == S_IDLE) && req_valid && !flush && (req_op <= 4'd8);

   // Operand ordering and FPnew op/modifier selection for the incoming request
   always_comb begin
      map_ops_s = 96'd0;
      map_op_s  = FP_ADD;
      map_mod_s = 1'b0;
      case (req_op)
         4'd0, 4'd1: begin
            map_ops_s = {req_b, req_a, 32'd0};
            map_op_s  = FP_ADD;
            map_mod_s = req_op[0];
         end
         4'd2: begin
            map_ops_s = {32'd0, req_b, req_a};
            map_op_s  = FP_MUL;
         end
         4'd3: begin
            map_ops_s = {32'd0, req_b, req_a};
            map_op_s  = FP_DIV;
         end
         4'd4: begin
            map_ops_s = {64'd0, req_a};
            map_op_s  = FP_SQRT;
         end
         4'd5, 4'd6: begin
            map_ops_s = {req_c, req_b, req_a};
            map_op_s  = FP_FMADD;
            map_mod_s = (req_op == 4'd6);
         end
         4'd7, 4'd8: begin
            map_ops_s = {req_c, req_b, req_a};
            map_op_s  = FP_FNMSUB;
            map_mod_s = (req_op == 4'd8);
         end
         default: begin
            map_ops_s = 96'd0;
            map_op_s  = FP_ADD;
            map_mod_s = 1'b0;
         end
      endcase
   end

   // Next-state, datapath capture, flag accumulation and timeout handling
   always_comb begin
      state_d     = state_q;
      ops_d       = ops_q;
      op_d        = op_q;
      mod_d       = mod_q;
      rm_d        = rm_q;
      rd_d        = rd_q;
      res_d       = res_q;
      status_d    = status_q;
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;
      fpu_flush_d = 1'b0;
      illegal_d   = 1'b0;
      if (fflags_clr) begin
         fflags_d = 5'd0;
      end else begin
         fflags_d = fflags_q;
      end

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               ops_d   = map_ops_s;
               op_d    = map_op_s;
               mod_d   = map_mod_s;
               rm_d    = req_rm;
               rd_d    = req_rd;
               cnt_d   = '0;
               state_d = S_ISSUE;
            end else if (req_valid && !flush && (req_op > 4'd8)) begin
               illegal_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (flush) begin
               fpu_flush_d = 1'b1;
               state_d     = S_IDLE;
            end else if (cnt_q == TO_LAST) begin
               fpu_flush_d = 1'b1;
               timeout_d   = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (fpu_in_ready) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               fpu_flush_d = 1'b1;
               state_d     = S_IDLE;
            end else if (fpu_out_valid) begin
               res_d    = fpu_result;
               status_d = fpu_status;
               state_d  = S_WB;
            end else if (cnt_q == TO_LAST) begin
               fpu_flush_d = 1'b1;
               timeout_d   = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WB: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (wb_ready) begin
               fflags_d = fflags_d | status_q;
               state_d  = S_IDLE;
            end else begin
               state_d = S_WB;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= S_IDLE;
         ops_q       <= 96'd0;
         op_q        <= 4'd0;
         mod_q       <= 1'b0;
         rm_q        <= 3'd0;
         rd_q        <= 5'd0;
         res_q       <= 32'd0;
         status_q    <= 5'd0;
         fflags_q    <= 5'd0;
         cnt_q       <= '0;
         fpu_flush_q <= 1'b0;
         illegal_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ops_q       <= ops_d;
         op_q        <= op_d;
         mod_q       <= mod_d;
         rm_q        <= rm_d;
         rd_q        <= rd_d;
         res_q       <= res_d;
         status_q    <= status_d;
         fflags_q    <= fflags_d;
         cnt_q       <= cnt_d;
         fpu_flush_q <= fpu_flush_d;
         illegal_q   <= illegal_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall         = (state_q != S_IDLE) || accept_s;
   assign fpu_operands  = ops_q;
   assign fpu_op        = op_q;
   assign fpu_op_mod    = mod_q;
   assign fpu_rnd       = rm_q;
   assign fpu_in_valid  = (state_q == S_ISSUE);
   assign fpu_out_ready = (state_q == S_WAIT);
   assign fpu_flush     = fpu_flush_q;
   assign wb_valid      = (state_q == S_WB);
   assign wb_rd         = rd_q;
   assign wb_data       = res_q;
   assign fflags        = fflags_q;
   assign illegal_op    = illegal_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_exu_fpu_seq.sv
// Bench for exu_fpu_seq: the bench plays the FPU and writeback, and checks
// operand ordering, handshake timing, flag accumulation, flush and timeout.
module tb_exu_fpu_seq;

   logic        clk;
   logic        rst_l;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_a, req_b, req_c;
   logic [4:0]  req_rd;
   logic [2:0]  req_rm;
   logic        flush;
   logic        stall;
   logic [95:0] fpu_operands;
   logic [3:0]  fpu_op;
   logic        fpu_op_mod;
   logic [2:0]  fpu_rnd;
   logic        fpu_in_valid;
   logic        fpu_in_ready;
   logic        fpu_flush;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_status;
   logic        fpu_out_valid;
   logic        fpu_out_ready;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic        illegal_op;
   logic        timeout_err;

   int          vec_cnt_r = 0;
   int          err_cnt_r = 0;
   logic [4:0]  model_ff_r = 5'd0;

   exu_fpu_seq #(.TIMEOUT(8)) dut (
      .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rd(req_rd), .req_rm(req_rm),
      .flush(flush), .stall(stall), .fpu_operands(fpu_operands), .fpu_op(fpu_op),
      .fpu_op_mod(fpu_op_mod), .fpu_rnd(fpu_rnd), .fpu_in_valid(fpu_in_valid),
      .fpu_in_ready(fpu_in_ready), .fpu_flush(fpu_flush), .fpu_result(fpu_result),
      .fpu_status(fpu_status), .fpu_out_valid(fpu_out_valid), .fpu_out_ready(fpu_out_ready),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .fflags(fflags), .fflags_clr(fflags_clr), .illegal_op(illegal_op),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vec_cnt_r++;
      if (got !== exp) begin
         err_cnt_r++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: FPnew operation code for each EXU op (ADD=2 MUL=3 DIV=4 SQRT=5 FMADD=0 FNMSUB=1)
   function automatic logic [3:0] ref_op(input logic [3:0] op);
      logic [3:0] tbl [0:8];
      tbl = '{4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd1, 4'd1};
      return tbl[op];
   endfunction

   function automatic logic ref_mod(input logic [3:0] op);
      return (op == 4'd1) || (op == 4'd6) || (op == 4'd8);
   endfunction

   // Reference operand slots {op2, op1, op0} built from the op's source list
   function automatic logic [95:0] ref_ops(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
      logic [31:0] s0, s1, s2;
      s0 = 32'd0; s1 = 32'd0; s2 = 32'd0;
      if (op <= 4'd1) begin
         s1 = a; s2 = b;
      end else if (op == 4'd4) begin
         s0 = a;
      end else begin
         s0 = a; s1 = b;
         if (op >= 4'd5) s2 = c;
      end
      return {s2, s1, s0};
   endfunction

   task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd, input logic [2:0] rm);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c;
      req_rd = rd; req_rm = rm;
      #1;
      check_eq("stall_accept", stall, 1'b1);
      tick();
      req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_c = $urandom;
      req_rd = 5'($urandom); req_rm = 3'($urandom);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] res, input logic [4:0] st,
                         input int in_dly, input int out_dly, input int wb_dly, input bit clr);
      logic [4:0] rd;
      logic [2:0] rm;
      rd = 5'($urandom);
      rm = 3'($urandom);
      accept(op, a, b, c, rd, rm);
      check_eq("in_valid", fpu_in_valid, 1'b1);
      check_eq("operands", fpu_operands, ref_ops(op, a, b, c));
      check_eq("fpu_op", fpu_op, ref_op(op));
      check_eq("fpu_mod", fpu_op_mod, ref_mod(op));
      check_eq("fpu_rnd", fpu_rnd, rm);
      for (int i = 0; i < in_dly; i++) tick();
      check_eq("in_valid_hold", fpu_in_valid, 1'b1);
      fpu_in_ready = 1'b1;
      tick();
      fpu_in_ready = 1'b0;
      check_eq("out_ready", fpu_out_ready, 1'b1);
      check_eq("in_valid_drop", fpu_in_valid, 1'b0);
      for (int i = 0; i < out_dly; i++) tick();
      check_eq("no_wb_early", wb_valid, 1'b0);
      fpu_out_valid = 1'b1; fpu_result = res; fpu_status = st;
      tick();
      fpu_out_valid = 1'b0; fpu_result = $urandom; fpu_status = 5'($urandom);
      check_eq("wb_valid", wb_valid, 1'b1);
      check_eq("wb_rd", wb_rd, rd);
      check_eq("wb_data", wb_data, res);
      for (int i = 0; i < wb_dly; i++) begin
         tick();
         check_eq("wb_hold_data", wb_data, res);
         check_eq("wb_hold_stall", stall, 1'b1);
      end
      wb_ready = 1'b1; fflags_clr = clr;
      tick();
      wb_ready = 1'b0; fflags_clr = 1'b0;
      model_ff_r = (clr ? 5'd0 : model_ff_r) | st;
      check_eq("wb_retired", wb_valid, 1'b0);
      check_eq("fflags", fflags, model_ff_r);
      check_eq("stall_after", stall, 1'b0);
   endtask

   initial begin
      rst_l = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
      req_c = 32'd0; req_rd = 5'd0; req_rm = 3'd0; flush = 1'b0; fpu_in_ready = 1'b0;
      fpu_result = 32'd0; fpu_status = 5'd0; fpu_out_valid = 1'b0; wb_ready = 1'b0;
      fflags_clr = 1'b0;
      #12;
      check_eq("rst_stall", stall, 1'b0);
      check_eq("rst_operands", fpu_operands, 96'd0);
      check_eq("rst_misc", {fpu_op, fpu_op_mod, fpu_rnd, fpu_in_valid, fpu_flush,
                            fpu_out_ready, wb_valid, wb_rd, wb_data, fflags,
                            illegal_op, timeout_err}, 96'd0);
      @(negedge clk);
      rst_l = 1'b1;
      tick();

      // Directed: ADD, MADD at minimum latency
      run_op(4'd0, 32'h3F800000, 32'h40000000, 32'h12345678, 32'h40400000, 5'd0, 0, 0, 0, 1'b0);
      run_op(4'd5, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 5'd0, 0, 0, 0, 1'b0);
      // DIV by zero, writeback held off for 5 cycles
      run_op(4'd3, 32'h3F800000, 32'h00000000, 32'h0, 32'h7F800000, 5'h08, 0, 0, 5, 1'b0);
      run_op(4'd2, 32'h3F800001, 32'h3F800001, 32'h0, 32'h3F800002, 5'h01, 1, 1, 0, 1'b0);
      check_eq("fflags_accum", fflags, 5'h09);
      run_op(4'd3, 32'h3F800000, 32'h00000000, 32'h0, 32'h7F800000, 5'h08, 0, 0, 5, 1'b1);
      check_eq("fflags_clr_retire", fflags, 5'h08);

      // Flush in the 3rd WAIT cycle coinciding with fpu_out_valid
      accept(4'd3, 32'h40800000, 32'h40000000, 32'h0, 5'd7, 3'd0);
      fpu_in_ready = 1'b1; tick(); fpu_in_ready = 1'b0;
      tick(); tick();
      flush = 1'b1; fpu_out_valid = 1'b1; fpu_result = 32'hDEADBEEF; fpu_status = 5'h1F;
      tick();
      flush = 1'b0; fpu_out_valid = 1'b0;
      check_eq("flush_pulse", fpu_flush, 1'b1);
      check_eq("flush_no_wb", wb_valid, 1'b0);
      check_eq("flush_stall", stall, 1'b0);
      check_eq("flush_fflags", fflags, model_ff_r);
      tick();
      check_eq("flush_once", fpu_flush, 1'b0);
      check_eq("flush_no_wb2", wb_valid, 1'b0);
      run_op(4'd4, 32'h40800000, 32'h0, 32'h0, 32'h40000000, 5'd0, 0, 1, 0, 1'b0);

      // Clear alone
      fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
      model_ff_r = 5'd0;
      check_eq("fflags_clr", fflags, 5'd0);

      // Timeout with the FPU never answering (TIMEOUT=8)
      accept(4'd0, 32'h1, 32'h2, 32'h3, 5'd3, 3'd1);
      fpu_in_ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         fpu_in_ready = 1'b0;
         if (k == 6) check_eq("to_not_yet", {timeout_err, fpu_flush}, 2'b00);
      end
      check_eq("to_err", timeout_err, 1'b1);
      check_eq("to_flush", fpu_flush, 1'b1);
      check_eq("to_no_wb", wb_valid, 1'b0);
      check_eq("to_stall", stall, 1'b0);
      tick();
      check_eq("to_flush_once", fpu_flush, 1'b0);
      run_op(4'd0, 32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'd0, 0, 0, 0, 1'b0);
      check_eq("to_sticky", timeout_err, 1'b1);

      // Illegal op
      req_valid = 1'b1; req_op = 4'd12; #1;
      check_eq("ill_stall", stall, 1'b0);
      tick();
      req_valid = 1'b0;
      check_eq("ill_pulse", illegal_op, 1'b1);
      check_eq("ill_no_issue", fpu_in_valid, 1'b0);
      tick();
      check_eq("ill_once", illegal_op, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         run_op(4'($urandom_range(0, 8)), $urandom, $urandom, $urandom, $urandom,
                5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end

      // Reset in the middle of an op
      accept(4'd2, 32'h5, 32'h6, 32'h7, 5'd9, 3'd2);
      fpu_in_ready = 1'b1; tick(); fpu_in_ready = 1'b0;
      #2 rst_l = 1'b0;
      #1;
      check_eq("rst_mid", {stall, fpu_flush, fpu_out_ready, wb_valid, fflags, timeout_err},
               10'd0);
      @(negedge clk);
      rst_l = 1'b1;
      model_ff_r = 5'd0;
      tick();
      run_op(4'd7, $urandom, $urandom, $urandom, 32'hC0000000, 5'h02, 0, 0, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt_r, err_cnt_r);
      $finish;
   end

endmodule

// File: doc/exu_fpu_seq.md
# exu_fpu_seq

Single-outstanding issue sequencer between the EXU decode/issue stage and the FPnew-based FP32 datapath. It latches one FP request, orders operands for the selected operation, and runs the FPU valid/ready handshakes. It captures the result, presents it to writeback, and accumulates sticky IEEE exception flags. It also owns pipeline stall, flush propagation and a hang-detect timeout.

## Interface
Parameters:
- TIMEOUT, 64: max cycles spent in ISSUE+WAIT before abort; legal range 4..1024.

Ports:
- clk  in  1  top-level clock
- rst_l  in  1  reset; asynchronous, active-low
- req_valid  in  1  FP op request from issue
- req_op  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SQRT, 5 MADD, 6 MSUB, 7 NMSUB, 8 NMADD; 9-15 illegal
- req_a / req_b / req_c  in  32 each  rs1/rs2/rs3 operands
- req_rd  in  5  destination register
- req_rm  in  3  rounding mode, passed through unchanged
- flush  in  1  kill any in-flight op
- stall  out  1  sequencer busy; issue must hold the next FP op
- fpu_operands  out  96  {op2, op1, op0}, 32 bits each
- fpu_op  out  4  fpnew_pkg::operation_e value
- fpu_op_mod  out  1  FPnew op modifier
- fpu_rnd  out  3  rounding mode to FPU
- fpu_in_valid  out  1
- fpu_in_ready  in  1
- fpu_flush  out  1
- fpu_result  in  32
- fpu_status  in  5  {NV, DZ, OF, UF, NX}
- fpu_out_valid  in  1
- fpu_out_ready  out  1
- wb_valid  out  1
- wb_ready  in  1
- wb_rd  out  5
- wb_data  out  32
- fflags  out  5  sticky, same bit order as fpu_status
- fflags_clr  in  1  clears fflags
- illegal_op  out  1  one-cycle pulse on an illegal req_op
- timeout_err  out  1  sticky; cleared only by reset

## Operation
- State machine states: IDLE, ISSUE, WAIT, WB.
- **IDLE**
  - When req_valid=1, flush=0 and req_op<=8: register operands, op, rm and rd; next state ISSUE.
  - When req_op>8: pulse illegal_op and stay in IDLE.
- **Operand and op mapping** (x = 0):
  - ADD/SUB: ops = {b, a, x}, op ADD, mod = SUB.
  - MUL: ops = {x, b, a}, op MUL.
  - DIV: ops = {x, b, a}, op DIV.
  - SQRT: ops = {x, x, a}, op SQRT.
  - MADD/MSUB: ops = {c, b, a}, op FMADD, mod = MSUB.
  - NMSUB/NMADD: ops = {c, b, a}, op FNMSUB, mod = NMADD.
- **ISSUE**: fpu_in_valid=1, outputs held stable. On fpu_in_ready=1 go to WAIT.
- **WAIT**: fpu_out_ready=1. On fpu_out_valid=1 capture fpu_result and fpu_status; next state WB.
- **WB**: wb_valid=1 with wb_rd and wb_data stable. On wb_ready=1, OR the captured status into fflags and go to IDLE.
- **fflags**:
  - fflags_clr alone: fflags <= 0.
  - fflags_clr in the same cycle as a WB retire: fflags <= new status only.
- **flush**:
  - In ISSUE or WAIT: fpu_flush=1 for exactly one cycle, result discarded, go to IDLE.
  - In WB: drop wb_valid, no fflags update, go to IDLE.
  - In IDLE: any request that cycle is ignored.
  - Flush takes priority over a simultaneous fpu_out_valid, fpu_in_ready or wb_ready.
- **Timeout**:
  - Counter of width $clog2(TIMEOUT+1); cleared on entry to ISSUE; increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT-1 without completion: set timeout_err, pulse fpu_flush, go to IDLE. Nothing is written back.

## Timing
- **Reset values**: state IDLE; all outputs 0, including fflags, timeout_err and the registered operand, op and rd fields.
- **stall**:
  - Asserted combinationally in the accept cycle (IDLE with req_valid).
  - Remains 1 through ISSUE, WAIT and WB.
  - Low in the cycle after the wb handshake or flush.
- **Minimum latency** (FPU in_ready=1 and out_valid the cycle after issue): accept at cycle 0, ISSUE at 1, WAIT at 2, wb_valid at 3.
- **Back-to-back**: the earliest next accept is the cycle after the WB retire.
- **Output stability**: fpu_in_valid and fpu_out_ready are registered-state decodes with no combinational path from fpu_in_ready or fpu_out_valid. wb_data is stable while wb_valid=1 and wb_ready=0.
- **Reset mid-op**: returns to IDLE immediately; no fpu_flush is generated (the FPU resets with the core).

## Test plan
- ADD a=0x3F800000, b=0x40000000; FPU model with in_ready=1 and 1-cycle latency -> wb_data=0x40400000, wb_rd echoed, wb_valid at cycle 3, fflags=0.
- MADD a=0x40000000, b=0x40400000, c=0x3F800000 -> fpu_operands={c,b,a}, fpu_op=FMADD, mod=0; wb_data=0x40E00000.
- DIV a=0x3F800000, b=0 with wb_ready held low for 5 cycles -> wb_data=0x7F800000 held stable throughout, stall=1 throughout, fflags=0x08 after retire. fflags_clr in the retire cycle -> fflags=0x08.
- DIV issued, then flush in the 3rd WAIT cycle coinciding with fpu_out_valid -> fpu_flush pulses once, no wb_valid, fflags unchanged, stall low next cycle, a new request is accepted.
- TIMEOUT=8, fpu_out_valid tied 0 -> timeout_err=1 and fpu_flush pulse exactly 7 cycles after entering ISSUE; the following ADD completes normally with timeout_err still 1.
- req_op=12 -> illegal_op 1-cycle pulse, stall stays 0, no fpu_in_valid.
